// File: rtl/pipeline_exe.sv
// Execute stage of the RV32 pipeline: ALU, branch/jump resolution and registered handoff to MEM.
// Define RV32M_DIV_EN to build the iterative 32-step divider; otherwise div/rem ops are illegal.
module pipeline_exe #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_d_i,
  input  logic [31:0] rs1_data_d_i,
  input  logic [31:0] rs2_data_d_i,
  input  logic [31:0] extended_imm_d_i,
  input  logic [31:0] pc_d_i,
  input  logic [3:0]  alu_op_d_i,
  input  logic        op_a_pc_d_i,
  input  logic        op_b_imm_d_i,
  input  logic [2:0]  branch_type_d_i,
  input  logic        jal_d_i,
  input  logic        jalr_d_i,
  input  logic [2:0]  dmem_type_d_i,
  input  logic        reg_write_en_d_i,
  input  logic [4:0]  rd_idx_d_i,
  input  logic [3:0]  result_src_d_i,
  input  logic        instr_illegal_d_i,
  input  logic        flush_e_i,
  output logic        stall_e_o,
  output logic        redirect_e_o,
  output logic [31:0] redirect_pc_e_o,
  output logic [31:0] alu_result_e_o,
  output logic [31:0] extended_imm_e_o,
  output logic [31:0] pc_plus4_e_o,
  output logic [2:0]  dmem_type_e_o,
  output logic        reg_write_en_e_o,
  output logic [4:0]  rd_idx_e_o,
  output logic [3:0]  result_src_e_o,
  output logic        instr_illegal_e_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;

  if (DIV_CYCLES != 32) begin : g_cfg_check
    $error("pipeline_exe: DIV_CYCLES must be 32 for RV32");
  end

  logic [XLEN-1:0] w_op_a, w_op_b, w_alu;
  logic [4:0]      w_shamt;
  logic            w_is_div_op, w_illegal, w_taken;
  logic            w_stall, w_div_done, w_issue;
  logic [XLEN-1:0] w_div_result;

  assign w_op_a      = op_a_pc_d_i  ? pc_d_i : rs1_data_d_i;
  assign w_op_b      = op_b_imm_d_i ? extended_imm_d_i : rs2_data_d_i;
  assign w_shamt     = w_op_b[4:0];
  assign w_is_div_op = (alu_op_d_i[3:2] == 2'b11);

  always_comb begin
    w_alu = '0;
    case (alu_op_d_i)
      4'd0:    w_alu = w_op_a + w_op_b;
      4'd1:    w_alu = w_op_a - w_op_b;
      4'd2:    w_alu = w_op_a << w_shamt;
      4'd3:    w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      4'd4:    w_alu = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
      4'd5:    w_alu = w_op_a ^ w_op_b;
      4'd6:    w_alu = w_op_a >> w_shamt;
      4'd7:    w_alu = $unsigned($signed(w_op_a) >>> w_shamt);
      4'd8:    w_alu = w_op_a | w_op_b;
      4'd9:    w_alu = w_op_a & w_op_b;
      default: w_alu = '0;
    endcase
  end

  // Branch compare is always rs1 vs rs2, independent of operand muxing.
  always_comb begin
    w_taken = 1'b0;
    case (branch_type_d_i)
      3'd1:    w_taken = (rs1_data_d_i == rs2_data_d_i);
      3'd2:    w_taken = (rs1_data_d_i != rs2_data_d_i);
      3'd3:    w_taken = ($signed(rs1_data_d_i) <  $signed(rs2_data_d_i));
      3'd4:    w_taken = ($signed(rs1_data_d_i) >= $signed(rs2_data_d_i));
      3'd5:    w_taken = (rs1_data_d_i <  rs2_data_d_i);
      3'd6:    w_taken = (rs1_data_d_i >= rs2_data_d_i);
      default: w_taken = 1'b0;
    endcase
  end

`ifdef RV32M_DIV_EN
  assign w_illegal = instr_illegal_d_i | (alu_op_d_i == 4'd10) | (alu_op_d_i == 4'd11) |
                     (branch_type_d_i == 3'd7);
`else
  assign w_illegal = instr_illegal_d_i | (alu_op_d_i == 4'd10) | (alu_op_d_i == 4'd11) |
                     (branch_type_d_i == 3'd7) | w_is_div_op;
`endif

  assign redirect_e_o    = resetn & valid_d_i & ~flush_e_i & ~w_illegal &
                           (w_taken | jal_d_i | jalr_d_i);
  assign redirect_pc_e_o = jalr_d_i ? ((rs1_data_d_i + extended_imm_d_i) & ~32'd1)
                                    : (pc_d_i + extended_imm_d_i);

`ifdef RV32M_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

  div_state_t      r_state, w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0] r_rem, r_quo, r_divisor;
  logic            r_neg_q, r_neg_r, r_is_rem;
  logic            w_start, w_signed, w_a_neg, w_b_neg, w_ge;
  logic [XLEN:0]   w_rem_sh, w_diff;
  logic [XLEN-1:0] w_q_fix, w_r_fix;

  assign w_start  = (r_state == S_IDLE) & valid_d_i & ~flush_e_i & w_is_div_op & ~w_illegal;
  assign w_signed = ~alu_op_d_i[0];
  assign w_a_neg  = w_signed & w_op_a[XLEN-1];
  assign w_b_neg  = w_signed & w_op_b[XLEN-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) begin
        w_next_state = S_BUSY;
        w_stall      = 1'b1;
      end
      S_BUSY: if (flush_e_i) begin
        w_next_state = S_IDLE;
      end else begin
        w_stall = 1'b1;
        if (r_count == CNT_W'(1)) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Restoring step: shift in the next dividend bit, subtract if it fits.
  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_divisor};
  assign w_ge     = ~w_diff[XLEN];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_is_rem  <= 1'b0;
    end else if (w_start) begin
      r_count   <= CNT_W'(DIV_CYCLES);
      r_rem     <= '0;
      r_quo     <= w_a_neg ? -w_op_a : w_op_a;
      r_divisor <= w_b_neg ? -w_op_b : w_op_b;
      // Divide by zero keeps an all-ones quotient regardless of signs.
      r_neg_q   <= (w_a_neg ^ w_b_neg) & (w_op_b != '0);
      r_neg_r   <= w_a_neg;
      r_is_rem  <= alu_op_d_i[1];
    end else if (r_state == S_BUSY) begin
      r_count <= r_count - CNT_W'(1);
      r_rem   <= w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
      r_quo   <= {r_quo[XLEN-2:0], w_ge};
    end
  end

  assign w_q_fix      = r_neg_q ? -r_quo : r_quo;
  assign w_r_fix      = r_neg_r ? -r_rem : r_rem;
  assign w_div_result = r_is_rem ? w_r_fix : w_q_fix;
  assign w_div_done   = (r_state == S_DONE);
  assign stall_e_o    = resetn & w_stall;
`else
  assign w_stall      = 1'b0;
  assign w_div_done   = 1'b0;
  assign w_div_result = '0;
  assign stall_e_o    = 1'b0;
`endif

  assign w_issue = valid_d_i & ~flush_e_i & ~w_stall;

  // Illegal instructions still reach MEM flagged, with side effects suppressed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alu_result_e_o    <= '0;
      extended_imm_e_o  <= '0;
      pc_plus4_e_o      <= '0;
      dmem_type_e_o     <= '0;
      reg_write_en_e_o  <= 1'b0;
      rd_idx_e_o        <= '0;
      result_src_e_o    <= '0;
      instr_illegal_e_o <= 1'b0;
    end else if (!w_issue) begin
      alu_result_e_o    <= '0;
      extended_imm_e_o  <= '0;
      pc_plus4_e_o      <= '0;
      dmem_type_e_o     <= '0;
      reg_write_en_e_o  <= 1'b0;
      rd_idx_e_o        <= '0;
      result_src_e_o    <= '0;
      instr_illegal_e_o <= 1'b0;
    end else begin
      alu_result_e_o    <= w_div_done ? w_div_result : w_alu;
      extended_imm_e_o  <= extended_imm_d_i;
      pc_plus4_e_o      <= pc_d_i + 32'd4;
      dmem_type_e_o     <= w_illegal ? 3'd0 : dmem_type_d_i;
      reg_write_en_e_o  <= reg_write_en_d_i & ~w_illegal;
      rd_idx_e_o        <= rd_idx_d_i;
      result_src_e_o    <= result_src_d_i;
      instr_illegal_e_o <= w_illegal;
    end
  end

endmodule
